// File: rtl/tictac_pkg.sv
// Shared tic-tac-toe definitions: keypad geometry, key codes and board bit mapping.
// The cell bit helpers are also used by the game-state block.
package tictac_pkg;

  localparam int N_ROWS = 4;
  localparam int N_COLS = 3;
  localparam int N_KEYS = N_ROWS * N_COLS;

  localparam logic [3:0] KEY_NONE  = 4'd0;
  localparam logic [3:0] KEY_STAR  = 4'd10;
  localparam logic [3:0] KEY_ZERO  = 4'd11;
  localparam logic [3:0] KEY_HASH  = 4'd12;
  // Internal-only code for ghosted frames; never reaches key_data
  localparam logic [3:0] KEY_MULTI = 4'd15;

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } key_state_t;

  function automatic int cell_o_bit(input int k);
    return 19 - 2 * k;
  endfunction

  function automatic int cell_x_bit(input int k);
    return 18 - 2 * k;
  endfunction

  // Frame bit i corresponds to key code i+1 (row-major, row0 = keys 1-3)
  function automatic logic [3:0] encode_frame(input logic [N_KEYS-1:0] f);
    logic [3:0] c;
    c = KEY_NONE;
    if ($countones(f) > 1) begin
      c = KEY_MULTI;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (f[i]) c = 4'(i + 1);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/keypad_move_encoder_scan.sv
// Column scanner: drives one-hot columns, samples row returns at the end of each slot
// and presents the assembled 12-bit frame with a one-clk frame_done strobe.
module keypad_scan
  import tictac_pkg::*;
#(
  parameter int SCAN_DIV = 25000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_ROWS-1:0] key_row,
  output logic [N_COLS-1:0] key_col,
  output logic              frame_done,
  output logic [N_KEYS-1:0] frame
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0]  div_cnt_reg;
  logic [N_COLS-1:0] key_col_reg;
  logic [N_KEYS-1:0] frame_acc_reg;
  logic [N_KEYS-1:0] sampled;
  logic              slot_end;

  assign slot_end = (div_cnt_reg == DIV_W'(SCAN_DIV - 1));

  // Merge the live row returns for the active column into the accumulated frame
  generate
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_sample
      assign sampled[gi] = key_col_reg[gi % N_COLS] ? key_row[gi / N_COLS] : frame_acc_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg   <= '0;
      key_col_reg   <= 3'b001;
      frame_acc_reg <= '0;
    end else if (slot_end) begin
      div_cnt_reg   <= '0;
      key_col_reg   <= {key_col_reg[N_COLS-2:0], key_col_reg[N_COLS-1]};
      frame_acc_reg <= sampled;
    end else begin
      div_cnt_reg   <= div_cnt_reg + 1'b1;
    end
  end

  assign key_col    = key_col_reg;
  assign frame_done = slot_end && key_col_reg[N_COLS-1];
  assign frame      = sampled;

endmodule

// File: rtl/keypad_move_encoder.sv
// Keypad-to-move encoder: debounces scanned frames, tracks press/release and emits
// one-clk key_valid (legal cell) or key_reject (occupied cell or * 0 #) per press.
module keypad_move_encoder
  import tictac_pkg::*;
#(
  parameter int SCAN_DIV        = 25000,
  parameter int DEBOUNCE_FRAMES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N_ROWS-1:0] key_row,
  input  logic [17:0]       board,
  output logic [N_COLS-1:0] key_col,
  output logic [3:0]        key_data,
  output logic              key_valid,
  output logic              key_reject
);

  localparam int STAB_W = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_FRAMES - 1);

  logic              frame_done;
  logic [N_KEYS-1:0] frame;
  logic [3:0]        code;
  logic [3:0]        prev_code_reg;
  logic              frame_seen_reg;
  logic [STAB_W-1:0] stab_cnt_reg, stab_cnt_next;
  key_state_t        state_reg, state_next;
  logic [3:0]        key_data_reg;
  logic              key_valid_reg, key_reject_reg;
  logic              valid_next, reject_next;
  logic              stable, press_event;
  logic [15:0]       cell_free;

  keypad_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_row    (key_row),
    .key_col    (key_col),
    .frame_done (frame_done),
    .frame      (frame)
  );

  // Indexed by key code: only cells 1..9 with neither O nor X set are playable
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_free
      if (gi >= 1 && gi <= 9) begin : g_cell
        assign cell_free[gi] = ~(board[cell_o_bit(gi)] | board[cell_x_bit(gi)]);
      end else begin : g_none
        assign cell_free[gi] = 1'b0;
      end
    end
  endgenerate

  assign code = encode_frame(frame);

  always_comb begin
    stab_cnt_next = stab_cnt_reg;
    state_next    = state_reg;
    press_event   = 1'b0;
    if (frame_done) begin
      if (frame_seen_reg && code == prev_code_reg) begin
        if (stab_cnt_reg != STAB_MAX) stab_cnt_next = stab_cnt_reg + 1'b1;
      end else begin
        stab_cnt_next = '0;
      end
    end
    stable = frame_done && frame_seen_reg && (stab_cnt_next == STAB_MAX);
    // A stable ghosted frame arms PRESSED silently so the key left behind cannot fire
    case (state_reg)
      RELEASED: if (stable && code != KEY_NONE) begin
        state_next  = PRESSED;
        press_event = (code != KEY_MULTI);
      end
      PRESSED:  if (stable && code == KEY_NONE) state_next = RELEASED;
      default:  state_next = RELEASED;
    endcase
    valid_next  = press_event && en && cell_free[code];
    reject_next = press_event && en && !cell_free[code];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_code_reg  <= KEY_NONE;
      frame_seen_reg <= 1'b0;
      stab_cnt_reg   <= '0;
      state_reg      <= RELEASED;
      key_data_reg   <= '0;
      key_valid_reg  <= 1'b0;
      key_reject_reg <= 1'b0;
    end else begin
      stab_cnt_reg   <= stab_cnt_next;
      state_reg      <= state_next;
      key_valid_reg  <= valid_next;
      key_reject_reg <= reject_next;
      if (valid_next) key_data_reg <= code;
      if (frame_done) begin
        prev_code_reg  <= code;
        frame_seen_reg <= 1'b1;
      end
    end
  end

  assign key_data   = key_data_reg;
  assign key_valid  = key_valid_reg;
  assign key_reject = key_reject_reg;

endmodule

// File: tb/tb_keypad_move_encoder.sv
// Bench for keypad_move_encoder: a keypad model answers the column drive, a step table
// pushes expected move events to a scoreboard, and a monitor pops them as pulses appear.
module tb_keypad_move_encoder;

  localparam int SD = 4;
  localparam int DF = 3;
  localparam int FR = 3 * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  key_row;
  logic [17:0] board = '0;
  logic [2:0]  key_col;
  logic [3:0]  key_data;
  logic        key_valid, key_reject;
  logic [11:0] keys_down = '0;

  keypad_move_encoder #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .key_row    (key_row),
    .board      (board),
    .key_col    (key_col),
    .key_data   (key_data),
    .key_valid  (key_valid),
    .key_reject (key_reject)
  );

  always #5 clk = ~clk;

  always_comb begin
    key_row = '0;
    for (int r = 0; r < 4; r++) key_row[r] = |(keys_down[r*3 +: 3] & key_col);
  end

  int edge_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  typedef struct {
    int         kind;   // 1 = key_valid, 2 = key_reject
    logic [3:0] data;   // key_data expected while the pulse is high
    int         at;     // edge_cnt value at the sampling point of the pulse
  } ev_t;
  ev_t sb[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (key_valid || key_reject)) begin
      ev_t e;
      check("pulse_exclusive", 32'(key_valid && key_reject), 32'd0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: valid=%0b reject=%0b data=%0d edge=%0d",
                 key_valid, key_reject, key_data, edge_cnt);
      end else begin
        e = sb.pop_front();
        check("ev_kind", key_valid ? 32'd1 : 32'd2, 32'(e.kind));
        check("ev_key_data", 32'(key_data), 32'(e.data));
        check("ev_latency", 32'(edge_cnt), 32'(e.at));
        $display("[TB] event kind=%0d data=%0d at edge %0d", e.kind, key_data, edge_cnt);
      end
    end
  end

  task automatic goto_frame(input int f);
    while (edge_cnt < FR * f) @(negedge clk);
  endtask

  typedef struct {
    logic [11:0] keys;
    int          nfr;
    logic        en;
    logic [17:0] board;
    int          kind;
    int          off;     // frame within the step at whose end stability is reached
    logic [3:0]  data;    // expected key_data at the end of the step
  } step_t;

  step_t steps[23];

  initial begin
    int s;
    logic [2:0] exp_col;

    steps[0]  = '{12'h010, 6, 1'b1, 18'd0,     1, 2, 4'd5};  // key 5 legal
    steps[1]  = '{12'h000, 4, 1'b1, 18'd0,     0, 0, 4'd5};
    steps[2]  = '{12'h010, 4, 1'b1, 18'h00200, 2, 2, 4'd5};  // O on cell 5
    steps[3]  = '{12'h000, 4, 1'b1, 18'h00200, 0, 0, 4'd5};
    steps[4]  = '{12'h001, 1, 1'b1, 18'd0,     0, 0, 4'd5};  // key 1 bounce
    steps[5]  = '{12'h000, 1, 1'b1, 18'd0,     0, 0, 4'd5};
    steps[6]  = '{12'h001, 1, 1'b1, 18'd0,     0, 0, 4'd5};
    steps[7]  = '{12'h000, 1, 1'b1, 18'd0,     0, 0, 4'd5};
    steps[8]  = '{12'h001, 1, 1'b1, 18'd0,     0, 0, 4'd5};
    steps[9]  = '{12'h001, 5, 1'b1, 18'd0,     1, 1, 4'd1};  // continues step 8
    steps[10] = '{12'h000, 4, 1'b1, 18'd0,     0, 0, 4'd1};
    steps[11] = '{12'h005, 4, 1'b1, 18'd0,     0, 0, 4'd1};  // keys 1+3 ghost
    steps[12] = '{12'h001, 4, 1'b1, 18'd0,     0, 0, 4'd1};  // key 3 let go
    steps[13] = '{12'h000, 4, 1'b1, 18'd0,     0, 0, 4'd1};
    steps[14] = '{12'h004, 4, 1'b1, 18'd0,     1, 2, 4'd3};  // key 3 alone
    steps[15] = '{12'h000, 4, 1'b1, 18'd0,     0, 0, 4'd3};
    steps[16] = '{12'h100, 4, 1'b0, 18'd0,     0, 0, 4'd3};  // key 9, en=0
    steps[17] = '{12'h100, 4, 1'b1, 18'd0,     0, 0, 4'd3};  // still held, en=1
    steps[18] = '{12'h000, 4, 1'b1, 18'd0,     0, 0, 4'd3};
    steps[19] = '{12'h200, 4, 1'b1, 18'd0,     2, 2, 4'd3};  // '*'
    steps[20] = '{12'h000, 4, 1'b1, 18'd0,     0, 0, 4'd3};
    steps[21] = '{12'h001, 4, 1'b1, 18'h10000, 2, 2, 4'd3};  // X on cell 1
    steps[22] = '{12'h000, 4, 1'b1, 18'd0,     0, 0, 4'd3};

    // Reset values, then column rotation and an idle stretch
    repeat (3) @(negedge clk);
    check("rst_key_col", 32'(key_col), 32'd1);
    check("rst_key_data", 32'(key_data), 32'd0);
    check("rst_pulses", 32'({key_valid, key_reject}), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      exp_col = 3'b001 << ((edge_cnt / SD) % 3);
      check("col_seq", 32'(key_col), 32'(exp_col));
    end
    goto_frame(17);
    check("idle_key_data", 32'(key_data), 32'd0);
    $display("[TB] idle done, key_data=%0d", key_data);

    for (int i = 0; i < 23; i++) begin
      s = edge_cnt / FR;
      keys_down = steps[i].keys;
      en        = steps[i].en;
      board     = steps[i].board;
      if (steps[i].kind != 0)
        sb.push_back('{steps[i].kind, steps[i].data, FR * (s + steps[i].off + 1)});
      goto_frame(s + steps[i].nfr);
      check("step_key_data", 32'(key_data), 32'(steps[i].data));
      $display("[TB] step %0d keys=%03h en=%0b key_data=%0d", i, steps[i].keys, steps[i].en, key_data);
    end

    // Reset in the middle of debouncing key 7; the held key must debounce afresh
    s = edge_cnt / FR;
    keys_down = 12'h040;
    goto_frame(s + 2);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_key_col", 32'(key_col), 32'd1);
    check("mid_rst_key_data", 32'(key_data), 32'd0);
    check("mid_rst_pulses", 32'({key_valid, key_reject}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{1, 4'd7, FR * 3});
    goto_frame(4);
    check("post_rst_key_data", 32'(key_data), 32'd7);
    $display("[TB] post-reset key_data=%0d", key_data);
    keys_down = '0;
    goto_frame(8);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
